// File: rtl/systolic_feeder.sv
// systolic_feeder: triangular-skew operand feeder for the left/top edges of an NxN systolic MAC array.
// Optional macro SYSTOLIC_FEEDER_STALL_CNT_EN adds the stall_cycles counter port.
module systolic_feeder #(
  parameter int N     = 8,
  parameter int A_W   = 8,
  parameter int W_W   = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] k_len,
  input  logic [N-1:0]     row_mask,
  input  logic [N-1:0]     col_mask,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*A_W-1:0] act_vec,
  input  logic [N*W_W-1:0] wgt_vec,
  output logic             arr_en,
  output logic [N-1:0]     arr_row_en,
  output logic [N-1:0]     arr_col_en,
  output logic [N*A_W-1:0] activation_out_flat,
  output logic [N*W_W-1:0] weight_out_flat,
  output logic             busy,
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_cycles,
`endif
  output logic             done
);
  localparam int FL_W = $clog2(2 * N);
  localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(2 * N - 3);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] k_len_r;
  logic [CNT_W-1:0] beat_cnt_r;
  logic [FL_W-1:0]  flush_cnt_r;
  logic [N-1:0]     row_mask_r;
  logic [N-1:0]     col_mask_r;
  logic             in_ready_r;
  logic             arr_en_r;
  logic             busy_r;
  logic             done_r;
  logic             stream_s;
  logic             advance_s;
  logic [N*A_W-1:0] act_feed_s;
  logic [N*W_W-1:0] wgt_feed_s;

  // Shift enable and the value entering every skew line (zero fill while flushing).
  always_comb begin
    stream_s  = (state_r == S_STREAM);
    advance_s = (stream_s && in_valid) || (state_r == S_FLUSH);
    if (stream_s) begin
      act_feed_s = act_vec;
      wgt_feed_s = wgt_vec;
    end else begin
      act_feed_s = {(N*A_W){1'b0}};
      wgt_feed_s = {(N*W_W){1'b0}};
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [A_W-1:0] act_line_r [0:i];
    logic [W_W-1:0] wgt_line_r [0:i];

    // Lane i skew line, i+1 stages deep; holds its contents on stall cycles.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int j = 0; j <= i; j++) begin
          act_line_r[j] <= {A_W{1'b0}};
          wgt_line_r[j] <= {W_W{1'b0}};
        end
      end else if (advance_s) begin
        act_line_r[0] <= act_feed_s[i*A_W +: A_W];
        wgt_line_r[0] <= wgt_feed_s[i*W_W +: W_W];
        for (int j = 1; j <= i; j++) begin
          act_line_r[j] <= act_line_r[j-1];
          wgt_line_r[j] <= wgt_line_r[j-1];
        end
      end
    end

    assign activation_out_flat[i*A_W +: A_W] = act_line_r[i];
    assign weight_out_flat[i*W_W +: W_W]     = wgt_line_r[i];
  end

  // Job sequencing FSM with all control outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      k_len_r     <= {CNT_W{1'b0}};
      beat_cnt_r  <= {CNT_W{1'b0}};
      flush_cnt_r <= {FL_W{1'b0}};
      row_mask_r  <= {N{1'b0}};
      col_mask_r  <= {N{1'b0}};
      in_ready_r  <= 1'b0;
      arr_en_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      arr_en_r <= advance_s;
      done_r   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            k_len_r     <= k_len;
            row_mask_r  <= row_mask;
            col_mask_r  <= col_mask;
            beat_cnt_r  <= {CNT_W{1'b0}};
            flush_cnt_r <= {FL_W{1'b0}};
            busy_r      <= 1'b1;
            if (k_len != {CNT_W{1'b0}}) begin
              state_r    <= S_STREAM;
              in_ready_r <= 1'b1;
            end else begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (in_valid) begin
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            if (beat_cnt_r == k_len_r - CNT_W'(1)) begin
              state_r    <= S_FLUSH;
              in_ready_r <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          flush_cnt_r <= flush_cnt_r + FL_W'(1);
          if (flush_cnt_r == FLUSH_LAST) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
          end
        end
        S_DONE: begin
          state_r    <= S_IDLE;
          busy_r     <= 1'b0;
          row_mask_r <= {N{1'b0}};
          col_mask_r <= {N{1'b0}};
        end
        default: begin
          state_r    <= S_IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          row_mask_r <= {N{1'b0}};
          col_mask_r <= {N{1'b0}};
        end
      endcase
    end
  end

`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;

  // Saturating count of STREAM cycles starved of input, restarted by each accepted job.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == S_IDLE) && start) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stream_s && !in_valid && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_r;
`endif

  assign in_ready   = in_ready_r;
  assign arr_en     = arr_en_r;
  assign arr_row_en = row_mask_r;
  assign arr_col_en = col_mask_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: job-level reference model plus table-driven job vectors.
module tb_systolic_feeder;
  localparam int N = 8, A_W = 8, W_W = 8, CNT_W = 16;
  localparam int P_IDLE = 0, P_STREAM = 1, P_FLUSH = 2, P_DONE = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] k_len = '0;
  logic [N-1:0]     row_mask = '0, col_mask = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N*A_W-1:0] act_vec = '0;
  logic [N*W_W-1:0] wgt_vec = '0;
  logic             arr_en;
  logic [N-1:0]     arr_row_en, arr_col_en;
  logic [N*A_W-1:0] activation_out_flat;
  logic [N*W_W-1:0] weight_out_flat;
  logic             busy, done;
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cycles;
`endif

  systolic_feeder #(.N(N), .A_W(A_W), .W_W(W_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .row_mask(row_mask), .col_mask(col_mask), .in_valid(in_valid), .in_ready(in_ready),
    .act_vec(act_vec), .wgt_vec(wgt_vec), .arr_en(arr_en),
    .arr_row_en(arr_row_en), .arr_col_en(arr_col_en),
    .activation_out_flat(activation_out_flat), .weight_out_flat(weight_out_flat),
    .busy(busy),
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit rand_data = 1'b1;

  // Reference model: job phase, beat/flush counts, and the list of accepted beats.
  int m_ph = P_IDLE, m_k = 0, m_got = 0, m_fl = 0, m_adv = 0;
  logic [N-1:0] m_rm = '0, m_cm = '0;
  logic m_en = 1'b0, m_done = 1'b0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [N*A_W-1:0] aq[$];
  logic [N*W_W-1:0] wq[$];

  typedef struct {
    int k; logic [N-1:0] rm; logic [N-1:0] cm; int sa; int sl;
    int exp_en; int exp_lat; int exp_stall;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  // After m advances, lane i shows the input of advance m-i (zero if it was a flush advance).
  function automatic logic [N*A_W-1:0] exp_act();
    logic [N*A_W-1:0] r, b;
    int idx;
    r = '0;
    for (int i = 0; i < N; i++) begin
      idx = m_adv - i - 1;
      if (idx >= 0 && idx < aq.size()) begin
        b = aq[idx];
        r[i*A_W +: A_W] = b[i*A_W +: A_W];
      end
    end
    return r;
  endfunction

  function automatic logic [N*W_W-1:0] exp_wgt();
    logic [N*W_W-1:0] r, b;
    int idx;
    r = '0;
    for (int i = 0; i < N; i++) begin
      idx = m_adv - i - 1;
      if (idx >= 0 && idx < wq.size()) begin
        b = wq[idx];
        r[i*W_W +: W_W] = b[i*W_W +: W_W];
      end
    end
    return r;
  endfunction

  task automatic step();
    bit adv;
    if (!rst_n) begin
      m_ph = P_IDLE; m_adv = 0; m_got = 0; m_fl = 0;
      aq.delete(); wq.delete();
      m_en = 1'b0; m_done = 1'b0; m_rm = '0; m_cm = '0; m_stall = '0;
    end else begin
      adv = (m_ph == P_STREAM && in_valid) || (m_ph == P_FLUSH);
      m_en = adv;
      m_done = 1'b0;
      if (adv) begin
        m_adv++;
        if (m_ph == P_STREAM) begin
          aq.push_back(act_vec);
          wq.push_back(wgt_vec);
        end
      end
      case (m_ph)
        P_IDLE: begin
          if (start) begin
            m_k = int'(k_len); m_rm = row_mask; m_cm = col_mask; m_stall = '0;
            m_adv = 0; m_got = 0; m_fl = 0; aq.delete(); wq.delete();
            m_ph = (m_k == 0) ? P_DONE : P_STREAM;
            m_done = (m_k == 0);
          end
        end
        P_STREAM: begin
          if (in_valid) begin
            m_got++;
            if (m_got == m_k) m_ph = P_FLUSH;
          end else if (m_stall != '1) begin
            m_stall++;
          end
        end
        P_FLUSH: begin
          m_fl++;
          if (m_fl == 2 * N - 2) begin
            m_ph = P_DONE;
            m_done = 1'b1;
          end
        end
        default: begin
          m_ph = P_IDLE; m_rm = '0; m_cm = '0;
        end
      endcase
    end
    @(posedge clk);
    #1;
    check("busy", busy, m_ph != P_IDLE);
    check("in_ready", in_ready, m_ph == P_STREAM);
    check("arr_en", arr_en, m_en);
    check("done", done, m_done);
    check("arr_row_en", arr_row_en, m_rm);
    check("arr_col_en", arr_col_en, m_cm);
    check("act_out", activation_out_flat, exp_act());
    check("wgt_out", weight_out_flat, exp_wgt());
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    check("stall_cycles", stall_cycles, m_stall);
`endif
  endtask

  task automatic randomize_data();
    if (rand_data) begin
      act_vec = {$urandom, $urandom};
      wgt_vec = {$urandom, $urandom};
    end
  endtask

  // Step until done is seen (bounded), then one more cycle so the feeder is back in IDLE.
  task automatic finish_job(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    check("done_reached", done, 1'b1);
    start = 1'b0;
    in_valid = 1'b0;
    step();
  endtask

  task automatic run_job(input int k, input logic [N-1:0] rm, input logic [N-1:0] cm,
                         input int sa, input int sl, output int en_cnt, output int lat);
    bit seen;
    seen = 1'b0;
    en_cnt = 0;
    lat = 0;
    start = 1'b1; k_len = CNT_W'(k); row_mask = rm; col_mask = cm;
    while (!seen && lat < 200) begin
      in_valid = !(lat >= sa && lat < sa + sl);
      randomize_data();
      step();
      start = 1'b0;
      lat++;
      en_cnt += int'(arr_en);
      if (done) seen = 1'b1;
    end
    check("job_done_seen", seen, 1'b1);
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    int en_cnt, lat, n;
    tbl[0] = '{4,  8'hFF, 8'hFF, 0, 0, 18, 19, 0};
    tbl[1] = '{3,  8'hFF, 8'hFF, 2, 2, 17, 20, 2};
    tbl[2] = '{0,  8'hA5, 8'h5A, 0, 0, 0,  1,  0};
    tbl[3] = '{1,  8'h0F, 8'hF0, 0, 0, 15, 16, 0};
    tbl[4] = '{10, 8'h3C, 8'hC3, 5, 3, 24, 28, 3};

    // Reset held with start and in_valid asserted.
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; k_len = 16'd5; row_mask = 8'hFF; col_mask = 8'hFF;
    repeat (3) step();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_act", activation_out_flat, 64'd0);
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    step();

    // Lane r carries r+1: lane 7 first shows 8 eight cycles after the first acceptance.
    rand_data = 1'b0;
    for (int r = 0; r < N; r++) begin
      act_vec[r*A_W +: A_W] = A_W'(r + 1);
      wgt_vec[r*W_W +: W_W] = W_W'(8'hF0 + r);
    end
    start = 1'b1; k_len = 16'd4; row_mask = 8'hFF; col_mask = 8'hFF; in_valid = 1'b1;
    step();
    start = 1'b0;
    step();
    check("lane0_t1", activation_out_flat[A_W-1:0], 8'd1);
    repeat (6) step();
    check("lane7_t7", activation_out_flat[7*A_W +: A_W], 8'd0);
    step();
    check("lane7_t8", activation_out_flat[7*A_W +: A_W], 8'd8);
    check("wlane7_t8", weight_out_flat[7*W_W +: W_W], 8'hF7);
    finish_job(40);
    rand_data = 1'b1;

    // Table-driven jobs: arr_en count, start-to-done latency, stall count.
    for (int t = 0; t < 5; t++) begin
      run_job(tbl[t].k, tbl[t].rm, tbl[t].cm, tbl[t].sa, tbl[t].sl, en_cnt, lat);
      check($sformatf("tbl%0d_en_cycles", t), en_cnt, tbl[t].exp_en);
      check($sformatf("tbl%0d_latency", t), lat, tbl[t].exp_lat);
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
      check($sformatf("tbl%0d_stalls", t), stall_cycles, tbl[t].exp_stall);
`endif
    end

    // start held while busy is ignored; the cycle after DONE accepts a new job.
    start = 1'b1; k_len = 16'd3; row_mask = 8'hFF; col_mask = 8'hFF; in_valid = 1'b1;
    step();
    k_len = 16'd0; row_mask = 8'h33;
    n = 0;
    while (!done && n < 100) begin
      randomize_data();
      step();
      n++;
    end
    check("busy_start_ignored_len", n, 17);
    k_len = 16'd2; row_mask = 8'h0F; col_mask = 8'h0F;
    step();
    check("start_in_done_ignored", busy, 1'b0);
    step();
    check("b2b_row_en", arr_row_en, 8'h0F);
    start = 1'b0;
    finish_job(40);

    // Reset in the middle of FLUSH: no done pulse, then a clean job.
    start = 1'b1; k_len = 16'd2; row_mask = 8'hFF; col_mask = 8'hFF; in_valid = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    check("midrst_done", done, 1'b0);
    check("midrst_arr_en", arr_en, 1'b0);
    check("midrst_row_en", arr_row_en, 8'h00);
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    run_job(4, 8'hFF, 8'hFF, 0, 0, en_cnt, lat);
    check("postrst_en_cycles", en_cnt, 18);
    check("postrst_latency", lat, 19);

    // Randomised traffic with occasional resets and stray starts.
    for (int c = 0; c < 800; c++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      start    = ($urandom_range(0, 5) == 0);
      k_len    = CNT_W'($urandom_range(0, 5));
      row_mask = N'($urandom);
      col_mask = N'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      randomize_data();
      step();
    end
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
